// File: rtl/wave_scale_pipe_pkg.sv
// Shared widths, defaults and types for the gain/offset scaling pipeline
// that sits between the SDRAM read stream and the DAC flow controller.
package wave_scale_pipe_pkg;

    localparam int WSP_DATA_NBIT = 20;   // AD5791 code width
    localparam int WSP_GAIN_NBIT = 16;   // signed Q1.(GAIN_NBIT-1)
    localparam int WSP_OUT_NBIT  = 32;   // SDRAM data width
    localparam int WSP_NSEL      = 8;
    localparam int WSP_SEL_NBIT  = 3;
    localparam int SAT_CNT_NBIT  = 16;

    // Per-stage control bits that travel alongside each sample.
    typedef struct packed {
        logic valid;
        logic last;
        logic sat;
    } stage_flags_t;

    // Largest positive Q1.(nbit-1) value, the closest representable gain to 1.0.
    function automatic logic [31:0] unity_gain(input int nbit);
        return (32'd1 << (nbit - 1)) - 32'd1;
    endfunction

endpackage

// File: rtl/wave_scale_pipe_if.sv
// Sample stream bundle: one word plus frame marker, with valid/ready flow control.
// A word transfers on every mclk edge where valid and ready are both high; the
// master holds valid, data and last stable until that edge, and ready may depend on valid.
interface wave_scale_pipe_if #(
    parameter int W = 20
);
    logic         valid;
    logic         ready;
    logic         last;
    logic [W-1:0] data;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/wave_sat_round.sv
// Combinational round-half-up right shift followed by saturation to a signed
// OUT_NBIT range; ovf flags that the result was clamped.
module wave_sat_round #(
    parameter int IN_NBIT  = 36,
    parameter int OUT_NBIT = 20,
    parameter int SHIFT    = 15
) (
    input  logic signed [IN_NBIT-1:0]  din,
    output logic signed [OUT_NBIT-1:0] dout,
    output logic                       ovf
);
    // One guard bit so adding the rounding half can never wrap.
    localparam int EXT_NBIT = IN_NBIT + 1;
    localparam logic signed [EXT_NBIT-1:0] HALF = EXT_NBIT'((2 ** SHIFT) / 2);
    localparam logic signed [EXT_NBIT-1:0] MAXV =
        {{(EXT_NBIT - OUT_NBIT + 1){1'b0}}, {(OUT_NBIT - 1){1'b1}}};
    localparam logic signed [EXT_NBIT-1:0] MINV = ~MAXV;

    logic signed [EXT_NBIT-1:0] ext;
    logic signed [EXT_NBIT-1:0] rnd;
    logic signed [EXT_NBIT-1:0] shf;

    always_comb begin
        ext = {din[IN_NBIT-1], din};
        rnd = ext + HALF;
        shf = rnd >>> SHIFT;
        if (shf > MAXV) begin
            dout = MAXV[OUT_NBIT-1:0];
            ovf  = 1'b1;
        end else if (shf < MINV) begin
            dout = MINV[OUT_NBIT-1:0];
            ovf  = 1'b1;
        end else begin
            dout = shf[OUT_NBIT-1:0];
            ovf  = 1'b0;
        end
    end
endmodule

// File: rtl/wave_scale_pipe.sv
// Three-stage offset -> gain -> round/saturate pipeline with a run-time coefficient
// table whose active entry only changes at frame boundaries or when idle.
module wave_scale_pipe
    import wave_scale_pipe_pkg::*;
#(
    parameter int DATA_NBIT = WSP_DATA_NBIT,
    parameter int GAIN_NBIT = WSP_GAIN_NBIT,
    parameter int OUT_NBIT  = WSP_OUT_NBIT,
    parameter int NSEL      = WSP_NSEL,
    parameter int SEL_NBIT  = WSP_SEL_NBIT
) (
    input  logic                    mclk,
    input  logic                    rst_n,
    wave_scale_pipe_if.slave        s,
    wave_scale_pipe_if.master       m,
    input  logic [SEL_NBIT-1:0]     sel,
    input  logic                    bypass,
    input  logic                    cfg_we,
    input  logic [SEL_NBIT-1:0]     cfg_addr,
    input  logic [GAIN_NBIT-1:0]    cfg_gain,
    input  logic [DATA_NBIT-1:0]    cfg_offset,
    input  logic                    sat_clr,
    output logic [SAT_CNT_NBIT-1:0] sat_cnt,
    output logic [SEL_NBIT-1:0]     active_sel
);
    localparam int PROD_NBIT = DATA_NBIT + GAIN_NBIT;
    localparam logic [GAIN_NBIT-1:0] GAIN_1 = GAIN_NBIT'(unity_gain(GAIN_NBIT));

    logic [GAIN_NBIT-1:0] tbl_gain [NSEL];
    logic [DATA_NBIT-1:0] tbl_off  [NSEL];

    logic signed [GAIN_NBIT-1:0] gain_act;
    logic signed [DATA_NBIT-1:0] off_act;
    logic                        bypass_act;

    stage_flags_t f1, f2, f3;
    logic signed [DATA_NBIT-1:0] sum1;
    logic signed [GAIN_NBIT-1:0] gain1;
    logic                        byp1;
    logic signed [PROD_NBIT-1:0] prod2;
    logic        [OUT_NBIT-1:0]  data3;

    logic                        en;
    logic                        accept;
    logic                        latch;
    logic signed [DATA_NBIT:0]   sum_wide;
    logic signed [DATA_NBIT-1:0] sum_sat;
    logic                        ovf1;
    logic signed [PROD_NBIT-1:0] prod_c;
    logic signed [DATA_NBIT-1:0] r3;
    logic                        ovf3;

    // Every stage advances together; a full output stage blocks the whole pipe.
    assign en      = ~f3.valid | m.ready;
    assign s.ready = en;
    assign accept  = s.valid & en;
    assign latch   = (accept & s.last) | (~(f1.valid | f2.valid | f3.valid) & ~s.valid);

    assign m.valid = f3.valid;
    assign m.data  = data3;
    assign m.last  = f3.last;

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NSEL; i++) begin
                tbl_gain[i] <= GAIN_1;
                tbl_off[i]  <= '0;
            end
        end else if (cfg_we) begin
            tbl_gain[cfg_addr] <= cfg_gain;
            tbl_off[cfg_addr]  <= cfg_offset;
        end
    end

    // Same-edge table writes are invisible here: the latch sees pre-write content.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            gain_act   <= GAIN_1;
            off_act    <= '0;
            bypass_act <= 1'b0;
            active_sel <= '0;
        end else if (latch) begin
            gain_act   <= tbl_gain[sel];
            off_act    <= tbl_off[sel];
            bypass_act <= bypass;
            active_sel <= sel;
        end
    end

    assign sum_wide = {s.data[DATA_NBIT-1], s.data} + {off_act[DATA_NBIT-1], off_act};

    wave_sat_round #(
        .IN_NBIT  (DATA_NBIT + 1),
        .OUT_NBIT (DATA_NBIT),
        .SHIFT    (0)
    ) u_sat_s1 (
        .din  (sum_wide),
        .dout (sum_sat),
        .ovf  (ovf1)
    );

    // Bypass scales by exactly 2^(GAIN_NBIT-1), which the S3 shift undoes losslessly.
    assign prod_c = byp1 ? (PROD_NBIT'(sum1) <<< (GAIN_NBIT - 1))
                         : PROD_NBIT'(sum1) * PROD_NBIT'(gain1);

    wave_sat_round #(
        .IN_NBIT  (PROD_NBIT),
        .OUT_NBIT (DATA_NBIT),
        .SHIFT    (GAIN_NBIT - 1)
    ) u_sat_s3 (
        .din  (prod2),
        .dout (r3),
        .ovf  (ovf3)
    );

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            f1    <= '0;
            f2    <= '0;
            f3    <= '0;
            sum1  <= '0;
            gain1 <= '0;
            byp1  <= 1'b0;
            prod2 <= '0;
            data3 <= '0;
        end else if (en) begin
            f1    <= '{valid: s.valid, last: s.valid & s.last, sat: ovf1 & ~bypass_act};
            sum1  <= bypass_act ? s.data : sum_sat;
            gain1 <= gain_act;
            byp1  <= bypass_act;
            f2    <= f1;
            prod2 <= prod_c;
            f3    <= '{valid: f2.valid, last: f2.last, sat: f2.sat | ovf3};
            data3 <= OUT_NBIT'(r3);
        end
    end

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            sat_cnt <= '0;
        end else if (sat_clr) begin
            sat_cnt <= '0;
        end else if (f3.valid && m.ready && f3.sat && (sat_cnt != '1)) begin
            sat_cnt <= sat_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_wave_scale_pipe.sv
// Directed and backpressure bench for wave_scale_pipe: fixed vectors with
// hand-derived results plus a random-stall stream against a reference model.
module tb_wave_scale_pipe;
    logic        mclk = 1'b0;
    logic        rst_n;
    logic [2:0]  sel;
    logic        bypass;
    logic        cfg_we;
    logic [2:0]  cfg_addr;
    logic [15:0] cfg_gain;
    logic [19:0] cfg_offset;
    logic        sat_clr;
    logic [15:0] sat_cnt;
    logic [2:0]  active_sel;

    wave_scale_pipe_if #(.W(20)) s_if ();
    wave_scale_pipe_if #(.W(32)) m_if ();

    wave_scale_pipe dut (
        .mclk       (mclk),
        .rst_n      (rst_n),
        .s          (s_if),
        .m          (m_if),
        .sel        (sel),
        .bypass     (bypass),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_gain   (cfg_gain),
        .cfg_offset (cfg_offset),
        .sat_clr    (sat_clr),
        .sat_cnt    (sat_cnt),
        .active_sel (active_sel)
    );

    always #5 mclk = ~mclk;

    int checks = 0;
    int errors = 0;

    logic [19:0] tx_d   [16];
    logic        tx_l   [16];
    logic [2:0]  tx_sel [16];
    logic [31:0] rx_d   [16];
    logic        rx_v   [16];
    logic        rx_l   [16];
    logic [2:0]  sel_log[16];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_clk();
        @(posedge mclk);
        #1;
    endtask

    task automatic cfg_write(input logic [2:0] a, input logic [15:0] g, input logic [19:0] o);
        cfg_we = 1'b1; cfg_addr = a; cfg_gain = g; cfg_offset = o;
        wait_clk();
        cfg_we = 1'b0;
    endtask

    // Idle cycles let the empty-pipeline latch pick up the new selection.
    task automatic select(input logic [2:0] k, input logic b);
        sel = k; bypass = b;
        repeat (2) wait_clk();
    endtask

    task automatic put(input int i, input logic [19:0] d, input logic l, input logic [2:0] sv);
        tx_d[i] = d; tx_l[i] = l; tx_sel[i] = sv;
    endtask

    // Back-to-back samples with m_ready high; captures each output and active_sel per cycle.
    task automatic stream(input int n);
        for (int i = 0; i < n + 2; i++) begin
            if (i < n) begin
                s_if.valid = 1'b1; s_if.data = tx_d[i]; s_if.last = tx_l[i]; sel = tx_sel[i];
            end else begin
                s_if.valid = 1'b0; s_if.last = 1'b0;
            end
            wait_clk();
            sel_log[i] = active_sel;
            if (i >= 2) begin
                rx_v[i-2] = m_if.valid; rx_d[i-2] = m_if.data; rx_l[i-2] = m_if.last;
            end
        end
        repeat (3) wait_clk();
    endtask

    function automatic logic [31:0] model(input logic [19:0] d, input logic [15:0] g,
                                          input logic [19:0] o);
        longint sum, prod, r;
        sum = longint'($signed(d)) + longint'($signed(o));
        if (sum > 524287) sum = 524287; else if (sum < -524288) sum = -524288;
        prod = sum * longint'($signed(g));
        r = (prod + 16384) >>> 15;
        if (r > 524287) r = 524287; else if (r < -524288) r = -524288;
        return 32'(r);
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; sel = 3'd0; bypass = 1'b0; cfg_we = 1'b0; cfg_addr = '0;
        cfg_gain = '0; cfg_offset = '0; sat_clr = 1'b0;
        s_if.valid = 1'b0; s_if.data = '0; s_if.last = 1'b0; m_if.ready = 1'b1;
        repeat (3) @(posedge mclk);
        #1 rst_n = 1'b1;
        wait_clk();
        checks++;
        if (m_if.valid !== 1'b0 || m_if.data !== 32'h0 || m_if.last !== 1'b0) begin
            errors++;
            $display("FAIL reset_out: got v=%b d=%h l=%b want 0 0 0", m_if.valid, m_if.data, m_if.last);
        end
        checks++;
        if (sat_cnt !== 16'h0 || active_sel !== 3'd0) begin
            errors++;
            $display("FAIL reset_state: got sat_cnt=%h active_sel=%0d want 0 0", sat_cnt, active_sel);
        end
        checks++;
        if (s_if.ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b want 1", s_if.ready);
        end
    endtask

    task automatic test_rounding();
        logic [31:0] e[4] = '{32'h0000_0100, 32'h0000_0001, 32'hFFFF_FF00, 32'h0007_FFEF};
        select(3'd0, 1'b0);
        put(0, 20'h00100, 1'b0, 3'd0); put(1, 20'h00001, 1'b0, 3'd0);
        put(2, 20'hFFF00, 1'b0, 3'd0); put(3, 20'h7FFFF, 1'b1, 3'd0);
        stream(4);
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (rx_v[j] !== 1'b1 || rx_d[j] !== e[j] || rx_l[j] !== (j == 3)) begin
                errors++;
                $display("FAIL unity[%0d]: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                         j, rx_v[j], rx_d[j], rx_l[j], e[j], (j == 3));
            end
        end
    endtask

    task automatic test_frame_switch();
        logic [31:0] e[5] = '{32'd1000, 32'd1000, 32'd1000, 32'd500, 32'd500};
        cfg_write(3'd1, 16'h4000, 20'h0);
        select(3'd0, 1'b0);
        put(0, 20'd1000, 1'b0, 3'd0); put(1, 20'd1000, 1'b0, 3'd1);
        put(2, 20'd1000, 1'b1, 3'd1); put(3, 20'd1000, 1'b0, 3'd1);
        put(4, 20'd1000, 1'b0, 3'd1);
        stream(5);
        for (int j = 0; j < 5; j++) begin
            checks++;
            if (rx_v[j] !== 1'b1 || rx_d[j] !== e[j] || rx_l[j] !== (j == 2)) begin
                errors++;
                $display("FAIL switch[%0d]: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                         j, rx_v[j], rx_d[j], rx_l[j], e[j], (j == 2));
            end
        end
        checks++;
        if (sel_log[1] !== 3'd0 || sel_log[2] !== 3'd1) begin
            errors++;
            $display("FAIL active_sel_timing: got %0d,%0d want 0,1", sel_log[1], sel_log[2]);
        end
    endtask

    task automatic test_offset_sat();
        logic [31:0] e[3] = '{32'h0004_0000, 32'h0000_0000, 32'h0004_0000};
        cfg_write(3'd2, 16'h4000, 20'h7FFFF);
        select(3'd2, 1'b0);
        put(0, 20'h00001, 1'b0, 3'd2); put(1, 20'h80000, 1'b0, 3'd2);
        put(2, 20'h00000, 1'b1, 3'd2);
        stream(3);
        for (int j = 0; j < 3; j++) begin
            checks++;
            if (rx_v[j] !== 1'b1 || rx_d[j] !== e[j]) begin
                errors++;
                $display("FAIL offset_sat[%0d]: got v=%b d=%h want v=1 d=%h", j, rx_v[j], rx_d[j], e[j]);
            end
        end
        checks++;
        if (sat_cnt !== 16'd1) begin
            errors++;
            $display("FAIL sat_cnt_s1: got %0d want 1", sat_cnt);
        end
    endtask

    task automatic test_neg_gain();
        logic [31:0] e[4] = '{32'h0007_FFFF, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF};
        cfg_write(3'd3, 16'h8000, 20'h0);
        select(3'd3, 1'b0);
        put(0, 20'h80000, 1'b0, 3'd3); put(1, 20'hFFFFF, 1'b0, 3'd3);
        put(2, 20'h00000, 1'b0, 3'd3); put(3, 20'h00001, 1'b1, 3'd3);
        stream(4);
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (rx_v[j] !== 1'b1 || rx_d[j] !== e[j]) begin
                errors++;
                $display("FAIL neg_gain[%0d]: got v=%b d=%h want v=1 d=%h", j, rx_v[j], rx_d[j], e[j]);
            end
        end
        checks++;
        if (sat_cnt !== 16'd2) begin
            errors++;
            $display("FAIL sat_cnt_s3: got %0d want 2", sat_cnt);
        end
        sat_clr = 1'b1;
        wait_clk();
        sat_clr = 1'b0;
        checks++;
        if (sat_cnt !== 16'd0) begin
            errors++;
            $display("FAIL sat_clr: got %0d want 0", sat_cnt);
        end
    endtask

    task automatic test_bypass();
        logic [31:0] e[3] = '{32'hFFF8_0000, 32'h0001_2345, 32'h0000_0001};
        select(3'd2, 1'b1);
        put(0, 20'h80000, 1'b0, 3'd2); put(1, 20'h12345, 1'b0, 3'd2);
        put(2, 20'h00001, 1'b1, 3'd2);
        stream(3);
        for (int j = 0; j < 3; j++) begin
            checks++;
            if (rx_v[j] !== 1'b1 || rx_d[j] !== e[j]) begin
                errors++;
                $display("FAIL bypass[%0d]: got v=%b d=%h want v=1 d=%h", j, rx_v[j], rx_d[j], e[j]);
            end
        end
        checks++;
        if (sat_cnt !== 16'd0) begin
            errors++;
            $display("FAIL bypass_sat: got %0d want 0", sat_cnt);
        end
    endtask

    task automatic test_backpressure();
        logic [32:0] exp_q[$];
        int n = 1000;
        cfg_write(3'd4, 16'h6000, 20'hFF000);
        select(3'd4, 1'b0);
        fork
            begin : drv
                for (int k = 0; k < n; k++) begin
                    logic [19:0] d;
                    logic        l;
                    logic        acc;
                    int          spins;
                    if ($urandom_range(0, 3) == 0) begin
                        s_if.valid = 1'b0;
                        wait_clk();
                    end
                    d = 20'($urandom());
                    l = ($urandom_range(0, 7) == 0);
                    s_if.valid = 1'b1; s_if.data = d; s_if.last = l;
                    acc = 1'b0; spins = 0;
                    while (!acc && spins < 100) begin
                        @(negedge mclk);
                        acc = s_if.ready;
                        @(posedge mclk);
                        #1;
                        spins++;
                    end
                    if (acc) exp_q.push_back({l, model(d, 16'h6000, 20'hFF000)});
                end
                s_if.valid = 1'b0; s_if.last = 1'b0;
            end
            begin : mon
                int          got = 0;
                int          cyc = 0;
                logic        stalled = 1'b0;
                logic [31:0] hd = '0;
                logic        hl = 1'b0;
                while (got < n && cyc < 20000) begin
                    @(posedge mclk);
                    #1;
                    m_if.ready = 1'($urandom_range(0, 1));
                    cyc++;
                    @(negedge mclk);
                    if (stalled) begin
                        checks++;
                        if (m_if.valid !== 1'b1 || m_if.data !== hd || m_if.last !== hl) begin
                            errors++;
                            $display("FAIL stall_hold: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                                     m_if.valid, m_if.data, m_if.last, hd, hl);
                        end
                    end
                    if (m_if.valid === 1'b1 && m_if.ready === 1'b1) begin
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL stream_extra: got d=%h with no sample pending", m_if.data);
                        end else begin
                            logic [32:0] e;
                            e = exp_q.pop_front();
                            if ({m_if.last, m_if.data} !== e) begin
                                errors++;
                                $display("FAIL stream_data[%0d]: got l=%b d=%h want l=%b d=%h",
                                         got, m_if.last, m_if.data, e[32], e[31:0]);
                            end
                        end
                        got++;
                        stalled = 1'b0;
                    end else begin
                        stalled = (m_if.valid === 1'b1);
                        hd = m_if.data;
                        hl = m_if.last;
                    end
                end
                checks++;
                if (got != n) begin
                    errors++;
                    $display("FAIL stream_count: got %0d outputs want %0d within cycle budget", got, n);
                end
                m_if.ready = 1'b1;
            end
        join
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL stream_lost: got %0d samples never delivered want 0", exp_q.size());
        end
    endtask

    task automatic test_reset_midframe();
        cfg_write(3'd0, 16'h4000, 20'h0);
        select(3'd0, 1'b0);
        s_if.valid = 1'b1; s_if.data = 20'h00100; s_if.last = 1'b0;
        repeat (3) wait_clk();
        checks++;
        if (m_if.valid !== 1'b1 || m_if.data !== 32'h0000_0080) begin
            errors++;
            $display("FAIL pre_reset: got v=%b d=%h want v=1 d=00000080", m_if.valid, m_if.data);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (m_if.valid !== 1'b0 || m_if.data !== 32'h0) begin
            errors++;
            $display("FAIL async_reset: got v=%b d=%h want 0 0", m_if.valid, m_if.data);
        end
        s_if.valid = 1'b0;
        wait_clk();
        rst_n = 1'b1;
        wait_clk();
        put(0, 20'h00100, 1'b1, 3'd0);
        stream(1);
        checks++;
        if (rx_v[0] !== 1'b1 || rx_d[0] !== 32'h0000_0100 || rx_l[0] !== 1'b1) begin
            errors++;
            $display("FAIL post_reset: got v=%b d=%h l=%b want v=1 d=00000100 l=1",
                     rx_v[0], rx_d[0], rx_l[0]);
        end
        checks++;
        if (active_sel !== 3'd0 || sat_cnt !== 16'd0) begin
            errors++;
            $display("FAIL post_reset_state: got sel=%0d sat=%0d want 0 0", active_sel, sat_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_rounding();
        test_frame_switch();
        test_offset_sat();
        test_neg_gain();
        test_bypass();
        test_backpressure();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
